// File: rtl/sme_param.sv
// sme_param: byte-serial string store plus parallel pattern window search.
// Supports '.' wildcard and optional '^'/'$' word anchors.
module sme_param #(
  parameter int CHAR_W    = 8,
  parameter int STR_MAX   = 32,
  parameter int PAT_MAX   = 8,
  parameter int ANCHOR_EN = 1,
  localparam int IDX_W    = $clog2(STR_MAX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  output logic              valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_index,
  output logic [IDX_W:0]    match_count,
  output logic              busy
);

  localparam int LW   = IDX_W + 1;
  localparam int PI_W = $clog2(PAT_MAX);
  localparam int PL_W = $clog2(PAT_MAX + 1);

  localparam logic [CHAR_W-1:0] DOT = CHAR_W'(8'h2E);
  localparam logic [CHAR_W-1:0] HAT = CHAR_W'(8'h5E);
  localparam logic [CHAR_W-1:0] DOL = CHAR_W'(8'h24);
  localparam logic [CHAR_W-1:0] SP  = CHAR_W'(8'h20);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_STR,
    LOAD_PAT,
    SEARCH,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CHAR_W-1:0] str_mem [STR_MAX];
  logic [CHAR_W-1:0] pat_mem [PAT_MAX];

  logic [LW-1:0]    str_len;
  logic [PL_W-1:0]  pat_len;
  logic [LW-1:0]    pos;
  logic [LW-1:0]    cnt;
  logic [IDX_W-1:0] first;
  logic             found;

  logic             str_we;
  logic [IDX_W-1:0] str_wa;
  logic             pat_we;
  logic [PI_W-1:0]  pat_wa;

  logic             hat;
  logic             dol;
  logic             body_ok;
  logic             hat_ok;
  logic             dol_ok;
  logic             fits;
  logic             hit;
  logic [CHAR_W-1:0] pc;
  int               plen;
  int               slen;
  int               pi;
  int               body_len;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (isstring)       state_nx = LOAD_STR;
        else if (ispattern) state_nx = LOAD_PAT;
      end
      LOAD_STR: begin
        if (!isstring) state_nx = IDLE;
      end
      LOAD_PAT: begin
        if (!ispattern)
          state_nx = (str_len == '0) ? DONE : SEARCH;
      end
      SEARCH: begin
        if (pos + 1'b1 == str_len) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Character write enables and addresses for both buffers
  always_comb begin
    str_we = 1'b0;
    str_wa = '0;
    pat_we = 1'b0;
    pat_wa = '0;
    if (reset) begin
      if (state == IDLE && isstring) begin
        str_we = 1'b1;
      end else if (state == IDLE && ispattern) begin
        pat_we = 1'b1;
      end else if (state == LOAD_STR && isstring &&
                   str_len < LW'(STR_MAX)) begin
        str_we = 1'b1;
        str_wa = str_len[IDX_W-1:0];
      end else if (state == LOAD_PAT && ispattern &&
                   pat_len < PL_W'(PAT_MAX)) begin
        pat_we = 1'b1;
        pat_wa = pat_len[PI_W-1:0];
      end
    end
  end

  // Character storage
  always_ff @(posedge clk) begin
    if (str_we) str_mem[str_wa] <= chardata;
    if (pat_we) pat_mem[pat_wa] <= chardata;
  end

  // Anchor parse and window compare for the current candidate
  always_comb begin
    plen     = int'(pat_len);
    slen     = int'(str_len);
    pi       = int'(pos);
    hat      = 1'b0;
    dol      = 1'b0;
    body_ok  = 1'b1;
    pc       = '0;
    if (ANCHOR_EN != 0 && plen > 0 && pat_mem[0] == HAT)
      hat = 1'b1;
    if (ANCHOR_EN != 0 && plen > int'(hat) &&
        pat_mem[PI_W'(plen - 1)] == DOL)
      dol = 1'b1;
    body_len = plen - int'(hat) - int'(dol);
    for (int j = 0; j < PAT_MAX; j++) begin
      if (j < body_len) begin
        pc = pat_mem[PI_W'(j + int'(hat))];
        if (pc != DOT &&
            (pi + j >= STR_MAX ||
             pc != str_mem[IDX_W'(pi + j)]))
          body_ok = 1'b0;
      end
    end
    fits   = (body_len > 0) && (pi + body_len <= slen);
    hat_ok = !hat || pi == 0 ||
             str_mem[IDX_W'(pi - 1)] == SP;
    dol_ok = !dol || pi + body_len == slen ||
             (pi + body_len < STR_MAX &&
              str_mem[IDX_W'(pi + body_len)] == SP);
    hit    = fits && body_ok && hat_ok && dol_ok;
  end

  // Lengths, search counters and registered results
  always_ff @(posedge clk) begin
    if (!reset) begin
      str_len     <= '0;
      pat_len     <= '0;
      pos         <= '0;
      cnt         <= '0;
      first       <= '0;
      found       <= 1'b0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
      match_count <= '0;
      busy        <= 1'b0;
    end else begin
      valid <= (state == DONE);
      busy  <= (state_nx == SEARCH) || (state_nx == DONE);
      unique case (state)
        IDLE: begin
          if (isstring)       str_len <= LW'(1);
          else if (ispattern) pat_len <= PL_W'(1);
        end
        LOAD_STR: begin
          if (isstring && str_len < LW'(STR_MAX))
            str_len <= str_len + 1'b1;
        end
        LOAD_PAT: begin
          if (ispattern && pat_len < PL_W'(PAT_MAX))
            pat_len <= pat_len + 1'b1;
          if (!ispattern) begin
            pos   <= '0;
            cnt   <= '0;
            first <= '0;
            found <= 1'b0;
          end
        end
        SEARCH: begin
          pos <= pos + 1'b1;
          if (hit) begin
            cnt <= cnt + 1'b1;
            if (!found) begin
              first <= pos[IDX_W-1:0];
              found <= 1'b1;
            end
          end
        end
        DONE: begin
          match       <= (cnt != '0);
          match_index <= first;
          match_count <= cnt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sme_param.sv
// tb_sme_param: directed bench for sme_param, anchored and literal builds.
// A queue-based reference predicts results and result timing each cycle.
module tb_sme_param;

  typedef byte bq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] chardata = '0;
  logic       isstring = 1'b0;
  logic       ispattern = 1'b0;

  logic       a_valid, a_match, a_busy;
  logic [4:0] a_idx;
  logic [5:0] a_cnt;
  logic       z_valid, z_match, z_busy;
  logic [4:0] z_idx;
  logic [5:0] z_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cyc = -1;
  int busy_from = -1;

  bq_t str_q;

  int pa_m, pa_i, pa_c, pz_m, pz_i, pz_c;
  int ha_m = 0, ha_i = 0, ha_c = 0;
  int hz_m = 0, hz_i = 0, hz_c = 0;

  sme_param #(.ANCHOR_EN(1)) dut_a (
    .clk(clk), .reset(reset), .chardata(chardata),
    .isstring(isstring), .ispattern(ispattern),
    .valid(a_valid), .match(a_match),
    .match_index(a_idx), .match_count(a_cnt),
    .busy(a_busy)
  );

  sme_param #(.ANCHOR_EN(0)) dut_z (
    .clk(clk), .reset(reset), .chardata(chardata),
    .isstring(isstring), .ispattern(ispattern),
    .valid(z_valid), .match(z_match),
    .match_index(z_idx), .match_count(z_cnt),
    .busy(z_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d want %0d",
               name, cyc, got, exp);
    end
  endtask

  function automatic bq_t to_q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference: scan every start position of the stored string.
  function automatic void model(input bq_t s, input string pat,
                                input bit anc, output int m,
                                output int idx, output int cnt);
    bq_t b;
    int  L, B;
    bit  h, d, ok;
    for (int i = 0; i < pat.len() && i < 8; i++)
      b.push_back(pat[i]);
    L = s.size();
    h = 0;
    d = 0;
    if (anc && b.size() > 0 && b[0] == 8'h5E) begin
      h = 1;
      void'(b.pop_front());
    end
    if (anc && b.size() > 0 && b[b.size()-1] == 8'h24) begin
      d = 1;
      void'(b.pop_back());
    end
    B = b.size();
    idx = 0;
    cnt = 0;
    for (int p = 0; p < L; p++) begin
      ok = (B > 0) && (p + B <= L);
      for (int j = 0; ok && j < B; j++)
        if (b[j] != 8'h2E && b[j] != s[p+j]) ok = 0;
      if (ok && h && p > 0 && s[p-1] != 8'h20) ok = 0;
      if (ok && d && p + B < L && s[p+B] != 8'h20) ok = 0;
      if (ok) begin
        if (cnt == 0) idx = p;
        cnt++;
      end
    end
    m = (cnt > 0) ? 1 : 0;
  endfunction

  // Edge bookkeeping: reset aborts, results become visible at valid
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      valid_cyc = -1;
      busy_from = -1;
      ha_m = 0; ha_i = 0; ha_c = 0;
      hz_m = 0; hz_i = 0; hz_c = 0;
    end else if (cyc == valid_cyc) begin
      ha_m = pa_m; ha_i = pa_i; ha_c = pa_c;
      hz_m = pz_m; hz_i = pz_i; hz_c = pz_c;
    end
  end

  // Per-cycle compare of both builds against the reference
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("a_valid", a_valid, cyc == valid_cyc);
      chk("a_busy", a_busy,
          busy_from >= 0 && cyc >= busy_from && cyc < valid_cyc);
      chk("a_match", a_match, ha_m);
      chk("a_index", a_idx, ha_i);
      chk("a_count", a_cnt, ha_c);
      chk("z_valid", z_valid, cyc == valid_cyc);
      chk("z_busy", z_busy,
          busy_from >= 0 && cyc >= busy_from && cyc < valid_cyc);
      chk("z_match", z_match, hz_m);
      chk("z_index", z_idx, hz_i);
      chk("z_count", z_cnt, hz_c);
    end
  end

  task automatic load_str(input string s);
    str_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      chardata = s[i];
      isstring = 1'b1;
      if (str_q.size() < 32) str_q.push_back(s[i]);
      @(posedge clk); #1;
    end
    isstring = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load_pat(input string pat, input bit wait_done,
                          input int la_m, input int la_i,
                          input int la_c, input int lz_m,
                          input int lz_i, input int lz_c);
    int n;
    for (int i = 0; i < pat.len(); i++) begin
      chardata = pat[i];
      ispattern = 1'b1;
      @(posedge clk); #1;
    end
    ispattern = 1'b0;
    model(str_q, pat, 1'b1, pa_m, pa_i, pa_c);
    model(str_q, pat, 1'b0, pz_m, pz_i, pz_c);
    busy_from = cyc + 1;
    valid_cyc = cyc + 1 + str_q.size() + 1;
    if (wait_done) begin
      n = 0;
      while (a_valid !== 1'b1 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      chk({"seen_valid ", pat}, a_valid, 1);
      chk({"lit_a_match ", pat}, a_match, la_m);
      chk({"lit_a_index ", pat}, a_idx, la_i);
      chk({"lit_a_count ", pat}, a_cnt, la_c);
      chk({"lit_z_match ", pat}, z_match, lz_m);
      chk({"lit_z_index ", pat}, z_idx, lz_i);
      chk({"lit_z_count ", pat}, z_cnt, lz_c);
    end
  endtask

  initial begin
    int m, i, c;

    model(to_q("banana"), "a.", 1'b1, m, i, c);
    chk("model_banana_count", c, 2);
    chk("model_banana_index", i, 1);
    model(to_q("the cat sat"), "^sat$", 1'b1, m, i, c);
    chk("model_anchor_index", i, 8);
    model(to_q("a^b"), "^b", 1'b0, m, i, c);
    chk("model_literal_match", m, 1);
    model(to_q("a^b"), "^b", 1'b1, m, i, c);
    chk("model_anchor_nomatch", m, 0);

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    load_str("the cat sat");
    load_pat("cat", 1, 1, 4, 1, 1, 4, 1);
    load_pat("^sat$", 1, 1, 8, 1, 0, 0, 0);

    load_str("banana");
    load_pat("a.", 1, 1, 1, 2, 1, 1, 2);

    load_str("hello");
    load_pat("xyz", 1, 0, 0, 0, 0, 0, 0);
    load_pat("^$", 1, 0, 0, 0, 0, 0, 0);

    load_str("abcdefghijklmnopqrstuvwxyz0123456789ABCD");
    load_pat(".", 1, 1, 0, 32, 1, 0, 32);
    load_pat("abcdefghXY", 1, 1, 0, 1, 1, 0, 1);
    load_pat("5", 1, 1, 31, 1, 1, 31, 1);
    load_pat("6", 1, 0, 0, 0, 0, 0, 0);

    load_str("a^b");
    load_pat("^b", 1, 0, 0, 0, 1, 1, 1);

    load_str("abcdef");
    load_pat("c", 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    str_q.delete();
    repeat (10) @(posedge clk);
    #1;
    load_pat("a", 1, 0, 0, 0, 0, 0, 0);

    chardata = "q";
    isstring = 1'b1;
    ispattern = 1'b1;
    @(posedge clk); #1;
    ispattern = 1'b0;
    chardata = "r";
    @(posedge clk); #1;
    chardata = "s";
    @(posedge clk); #1;
    isstring = 1'b0;
    str_q = to_q("qrs");
    repeat (3) @(posedge clk);
    #1;
    load_pat("qrs", 1, 1, 0, 1, 1, 0, 1);
    load_pat("s$", 1, 1, 2, 1, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sme_param.md
# sme_param

Parametrised string-matching engine, successor to the fixed 32x8 SME. It stores one string and matches any number of subsequent patterns against it, with `.` wildcard and optional `^`/`$` anchors. It reports the first match position and the total number of matching positions. It uses the same byte-serial `isstring`/`ispattern` load protocol and the same one-cycle `valid` result strobe as SME, so it drops into the existing pattern-file benches.

## Interface
- `CHAR_W`, default 8: character width in bits.
- `STR_MAX`, default 32: maximum stored string length.
- `PAT_MAX`, default 8: maximum stored pattern length, including anchors.
- `ANCHOR_EN`, default 1: when 1, `^` (0x5E) and `$` (0x24) are anchors; when 0, they are literal characters.
- `IDX_W` is a localparam, fixed at `$clog2(STR_MAX)`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `chardata`  in  CHAR_W  character sampled on each rising edge where `isstring` or `ispattern` is 1.
- `isstring`  in  1  string load strobe.
- `ispattern`  in  1  pattern load strobe.
- `valid`  out  1  one-cycle result strobe.
- `match`  out  1  1 when at least one position matched.
- `match_index`  out  IDX_W  lowest matching position.
- `match_count`  out  IDX_W+1  number of matching positions.
- `busy`  out  1  1 while the engine is searching; inputs are ignored during this time.

## Operation
- FSM states are IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE.
- IDLE
  - `isstring`=1: go to LOAD_STR. The string write pointer resets to 0 and the first character is stored.
  - Else `ispattern`=1: go to LOAD_PAT. The pattern write pointer resets to 0 and the first character is stored.
  - If both are 1, `isstring` wins and the pattern character is dropped.
- LOAD_STR
  - Stores one character per edge while `isstring`=1.
  - Characters beyond STR_MAX are discarded.
  - `str_len` is the number of characters stored.
  - On `isstring`=0, return to IDLE.
  - A new string overwrites the previous one. The stored string persists across patterns.
- LOAD_PAT
  - Stores one character per edge while `ispattern`=1.
  - Characters beyond PAT_MAX are discarded.
  - On `ispattern`=0, go to SEARCH with candidate position p=0.
- Pattern parse (when ANCHOR_EN=1)
  - A leading `^` sets the `hat` flag.
  - A trailing `$` sets the `dol` flag.
  - The remaining characters form the body, of length B.
  - `.` (0x2E) in the body matches any character.
- SEARCH: evaluates one candidate p per cycle, for p = 0 .. str_len-1. All B body comparators run in parallel. Candidate p matches iff all of these hold:
  - B>0 and p+B ≤ str_len.
  - Every body position j matches `str[p+j]`.
  - If `hat`: p==0 or `str[p-1]`==0x20.
  - If `dol`: p+B==str_len or `str[p+B]`==0x20.
- On each matching candidate:
  - The match counter increments (saturating is not needed, since count ≤ STR_MAX).
  - The first hit latches p as the index.
- After p=str_len-1, go to DONE. If str_len==0, go straight to DONE with no match.
- DONE
  - Registers `match`=(count>0), `match_index`=latched p (0 if none), `match_count`=count.
  - Pulses `valid`, then returns to IDLE.
- Result outputs hold their values until the next DONE.
- A pattern with no intervening string reuses the stored string.
- A pattern before any string gives match=0, count=0.
- `reset`=0 on any edge:
  - FSM goes to IDLE; str_len, pattern length and counters clear.
  - All outputs go to 0, including during SEARCH.
  - No `valid` pulse is produced for an aborted search.

## Timing
- Reset value is 0 for all outputs: `valid`, `match`, `match_index`, `match_count`, `busy`.
- Let E be the first edge at which `ispattern` is sampled 0 after a pattern. Then:
  - `busy`=1 from E until the DONE edge.
  - `valid` is high for exactly one cycle, after edge E+str_len+1.
- Search latency is deterministic and independent of match outcome. There is no early exit, because all positions must be scanned to produce `match_count`.
- `isstring`/`ispattern` asserted while `busy`=1 are ignored. The bench must wait for `valid` before the next load, as the existing SME bench already does.
- Back-to-back loads are legal: a string burst may be followed on the very next edge by a pattern burst.

## Test plan
- Anchors and wildcard: string "the cat sat" (L=11), then patterns "cat" and "^sat$".
  - "cat": match=1, index=4, count=1, valid 12 edges after E.
  - "^sat$": match=1, index=8, count=1.
- Wildcard with multiple hits: pattern "a." on string "banana".
  - match=1, index=1, count=2 ("an" at 1, "an" at 3; "a" at 5 fails because p+B>L).
- No match and empty body: string "hello".
  - Pattern "xyz": match=0, count=0, index=0.
  - Pattern "^$": B=0, so match=0.
- Overflow and reuse, with STR_MAX=32 and PAT_MAX=8:
  - A 40-character string stores only 32 characters; pattern "." gives count=32.
  - A 10-character pattern is truncated to 8 characters.
  - A second pattern without a new string matches the retained string.
- Literal anchors: ANCHOR_EN=0, string "a^b", pattern "^b" → match=1, index=1.
- Reset and collision:
  - `reset`=0 for one edge mid-SEARCH: no `valid` pulse, all outputs 0, next pattern sees str_len=0 → match=0.
  - `isstring` and `ispattern` both 1 from IDLE: the string is loaded and the pattern is dropped.
